// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS unified-memory arbiter.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } grant_e;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 15;

   // The watchdog only ever needs to hold 0 .. TIMEOUT-1.
   function automatic int tmo_cnt_w(input int timeout);
      return (timeout > 2) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Watchdog for a memory access: counts cycles without mem_ack and flags
// expiry once the count has reached TIMEOUT-1.
module mem_timeout_counter
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CNT_W = tmo_cnt_w(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;

   // Saturates at the terminal value so a stalled enable can never wrap.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != CNT_LAST)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign expired_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Fetch/data arbiter for the unified single-port memory of the multicycle MIPS core.
// Define MIPS_MEM_ARB_RR_EN for round-robin arbitration instead of data-over-fetch priority.
//
// state | meaning
// IDLE  | sample if_req/d_req, latch the winner onto mem_*
// BUSY  | mem_req high, wait for mem_ack or watchdog expiry
// RESP  | one-cycle ack (and bus_err on timeout) to the granted requester
module mips_mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_ack_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              bus_err_o,
   output logic              busy_o
);

   state_e            state_q;
   grant_e            gnt_q;
   grant_e            pick;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              if_ack_q;
   logic              d_ack_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              bus_err_q;
   logic              busy_q;
   logic              tmo_expired;
   logic              in_busy;

`ifdef MIPS_MEM_ARB_RR_EN
   grant_e last_q;

   always_comb begin
      pick = GNT_IF;
      if (d_req_i && if_req_i) begin
         pick = (last_q == GNT_D) ? GNT_IF : GNT_D;
      end else if (d_req_i) begin
         pick = GNT_D;
      end
   end
`else
   assign pick = d_req_i ? GNT_D : GNT_IF;
`endif

   assign in_busy = (state_q == BUSY);

   mem_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (!in_busy),
      .en_i      (in_busy && !mem_ack_i),
      .expired_o (tmo_expired)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         gnt_q       <= GNT_IF;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         bus_err_q   <= 1'b0;
         busy_q      <= 1'b0;
`ifdef MIPS_MEM_ARB_RR_EN
         last_q      <= GNT_IF;
`endif
      end else begin
         if_ack_q  <= 1'b0;
         d_ack_q   <= 1'b0;
         bus_err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (if_req_i || d_req_i) begin
                  gnt_q     <= pick;
                  mem_req_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= BUSY;
`ifdef MIPS_MEM_ARB_RR_EN
                  last_q    <= pick;
`endif
                  if (pick == GNT_D) begin
                     mem_we_q    <= d_we_i;
                     mem_addr_q  <= d_addr_i;
                     mem_wdata_q <= d_wdata_i;
                  end else begin
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= if_addr_i;
                     mem_wdata_q <= '0;
                  end
               end
            end
            BUSY: begin
               // An ack in the last counted cycle takes precedence over expiry.
               if (mem_ack_i || tmo_expired) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  bus_err_q <= !mem_ack_i;
                  state_q   <= RESP;
                  if (gnt_q == GNT_D) begin
                     d_ack_q   <= 1'b1;
                     d_rdata_q <= (mem_ack_i && !mem_we_q) ? mem_rdata_i : '0;
                  end else begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= mem_ack_i ? mem_rdata_i : '0;
                  end
               end
            end
            RESP: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_ack_o    = if_ack_q;
   assign d_ack_o     = d_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rdata_o   = d_rdata_q;
   assign bus_err_o   = bus_err_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios plus randomized
// traffic checked against a timing/arbitration model of the arbiter's rules.
module tb_mips_mem_arbiter;

   localparam int T = 15;
`ifdef MIPS_MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        if_ack_o, d_ack_o, mem_req_o, mem_we_o, bus_err_o, busy_o;
   logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;

   int checks = 0;
   int errors = 0;

   // memory responder controls
   int          lat_mode = 0;
   int          fix_lat  = 1;
   int          cur_lat  = 1;
   int          nreq     = 0;
   bit          stray_en = 1'b0;
   bit          force_ack = 1'b0;
   bit          use_fix_rd = 1'b0;
   logic [31:0] fix_rd = 32'h0;
   logic [31:0] salt = 32'h1234_5678;

   always #5 clk = ~clk;

   mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_ack_o    (if_ack_o),
      .if_rdata_o  (if_rdata_o),
      .d_req_i     (d_req),
      .d_we_i      (d_we),
      .d_addr_i    (d_addr),
      .d_wdata_i   (d_wdata),
      .d_ack_o     (d_ack_o),
      .d_rdata_o   (d_rdata_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack),
      .mem_rdata_i (mem_rdata),
      .bus_err_o   (bus_err_o),
      .busy_o      (busy_o)
   );

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   // Memory model: acks in the cur_lat-th cycle of a strobe; junk data otherwise.
   initial begin
      bit hit;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_req_o === 1'b1) begin
            nreq++;
            if (nreq == 1) begin
               if (lat_mode == 0) begin
                  cur_lat = fix_lat;
               end else begin
                  case ($urandom_range(0, 9))
                     0:       cur_lat = T;
                     1:       cur_lat = T + 1;
                     2:       cur_lat = T - 1;
                     default: cur_lat = $urandom_range(1, 4);
                  endcase
               end
            end
         end else begin
            nreq = 0;
         end
         hit = (mem_req_o === 1'b1) && (nreq == cur_lat);
         mem_ack = hit || force_ack ||
                   (stray_en && (mem_req_o !== 1'b1) && ($urandom_range(0, 1) == 1));
         mem_rdata = hit ? (use_fix_rd ? fix_rd : rd_fn(mem_addr_o)) : $urandom;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "time limit");
   end

   task automatic reset_dut();
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
      force_ack = 1'b0; stray_en = 1'b0; lat_mode = 0; use_fix_rd = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      force_ack = 1'b1; lat_mode = 0; fix_lat = 1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ack_o, d_ack_o,
              if_rdata_o, d_rdata_o, bus_err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h ia=%b da=%b ird=%h drd=%h err=%b, expected all 0",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ack_o, d_ack_o,
                     if_rdata_o, d_rdata_o, bus_err_o);
         end
         checks++;
         if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy_o);
         end
      end
      reset_dut();
   endtask

   task automatic test_single_fetch();
      reset_dut();
      fix_lat = 3; use_fix_rd = 1'b1; fix_rd = 32'h8C01_0004;
      if_addr = 32'h0000_0010; if_req = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         checks++;
         if (mem_req_o !== (c >= 1 && c <= 3)) begin
            errors++;
            $display("FAIL sf_mem_req c=%0d: got %b expected %b", c, mem_req_o, (c >= 1 && c <= 3));
         end
         checks++;
         if (if_ack_o !== (c == 4) || d_ack_o !== 1'b0 || bus_err_o !== 1'b0) begin
            errors++;
            $display("FAIL sf_ack c=%0d: got if_ack=%b d_ack=%b bus_err=%b expected %b 0 0",
                     c, if_ack_o, d_ack_o, bus_err_o, (c == 4));
         end
         if (c == 1) begin
            checks++;
            if (mem_addr_o !== 32'h10 || mem_we_o !== 1'b0) begin
               errors++;
               $display("FAIL sf_mem_addr: got %h we=%b expected 00000010 we=0", mem_addr_o, mem_we_o);
            end
         end
         if (c == 4) begin
            checks++;
            if (if_rdata_o !== 32'h8C01_0004) begin
               errors++;
               $display("FAIL sf_rdata: got %h expected 8c010004", if_rdata_o);
            end
         end
         @(posedge clk); #1;
         if (c == 4) if_req = 1'b0;
      end
      use_fix_rd = 1'b0;
   endtask

   task automatic test_contention();
      bit          first_d;
      logic [31:0] fa, a_first, a_second;
      reset_dut();
      fix_lat = 1; salt = $urandom;
      for (int r = 0; r < 2; r++) begin
         if (r == 1) begin
            // lone data access so that the last grant is the data port
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               checks++;
               if (d_ack_o !== (c == 2)) begin
                  errors++;
                  $display("FAIL ct_lone_d_ack c=%0d: got %b expected %b", c, d_ack_o, (c == 2));
               end
               @(posedge clk); #1;
               if (c == 2) d_req = 1'b0;
            end
         end
         fa = $urandom & 32'hFFFF_FFFC;
         if_addr = fa; if_req = 1'b1;
         d_addr = 32'h100; d_we = 1'b0; d_req = 1'b1;
         first_d = (r == 0) ? 1'b1 : !RR;
         a_first  = first_d ? 32'h100 : fa;
         a_second = first_d ? fa : 32'h100;
         for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++;
            if (if_ack_o !== (first_d ? (c == 5) : (c == 2)) ||
                d_ack_o  !== (first_d ? (c == 2) : (c == 5))) begin
               errors++;
               $display("FAIL ct_acks r=%0d c=%0d: got if_ack=%b d_ack=%b, data_first=%b",
                        r, c, if_ack_o, d_ack_o, first_d);
            end
            if (c == 1 || c == 4) begin
               checks++;
               if (mem_addr_o !== ((c == 1) ? a_first : a_second)) begin
                  errors++;
                  $display("FAIL ct_mem_addr r=%0d c=%0d: got %h expected %h",
                           r, c, mem_addr_o, (c == 1) ? a_first : a_second);
               end
            end
            if (c == 5) begin
               checks++;
               if (if_rdata_o !== rd_fn(fa) || d_rdata_o !== rd_fn(32'h100)) begin
                  errors++;
                  $display("FAIL ct_rdata r=%0d: got if=%h d=%h expected if=%h d=%h",
                           r, if_rdata_o, d_rdata_o, rd_fn(fa), rd_fn(32'h100));
               end
            end
            @(posedge clk); #1;
            if (c == 2) begin
               if (first_d) d_req = 1'b0; else if_req = 1'b0;
            end
            if (c == 5) begin
               if_req = 1'b0; d_req = 1'b0;
            end
         end
      end
   endtask

   task automatic test_store();
      int          lat;
      logic [31:0] a;
      reset_dut();
      salt = $urandom;
      for (int k = 0; k < 2; k++) begin
         lat = $urandom_range(1, 4);
         fix_lat = lat;
         a = (k == 1) ? 32'h20 : 32'h24;
         d_req = 1'b1; d_we = (k == 1); d_addr = a;
         d_wdata = (k == 1) ? 32'hDEAD_BEEF : $urandom;
         for (int c = 0; c <= lat + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
               checks++;
               if (mem_we_o !== (k == 1) || mem_addr_o !== a ||
                   ((k == 1) && mem_wdata_o !== 32'hDEAD_BEEF)) begin
                  errors++;
                  $display("FAIL st_mem k=%0d: got we=%b addr=%h wd=%h expected we=%b addr=%h",
                           k, mem_we_o, mem_addr_o, mem_wdata_o, (k == 1), a);
               end
            end
            checks++;
            if (d_ack_o !== (c == lat + 1) || bus_err_o !== 1'b0) begin
               errors++;
               $display("FAIL st_ack k=%0d c=%0d: got d_ack=%b err=%b expected %b 0",
                        k, c, d_ack_o, bus_err_o, (c == lat + 1));
            end
            if (c == lat + 1) begin
               checks++;
               if (d_rdata_o !== ((k == 1) ? 32'h0 : rd_fn(a))) begin
                  errors++;
                  $display("FAIL st_rdata k=%0d: got %h expected %h",
                           k, d_rdata_o, (k == 1) ? 32'h0 : rd_fn(a));
               end
            end
            @(posedge clk); #1;
            if (c == lat + 1) d_req = 1'b0;
         end
      end
   endtask

   task automatic test_timeout();
      int          hi, ackc;
      bit          exp_err;
      logic [31:0] a;
      reset_dut();
      salt = $urandom;
      for (int r = 0; r < 2; r++) begin
         fix_lat = (r == 0) ? T : 1000;
         exp_err = (r == 1);
         a = $urandom;
         d_req = 1'b1; d_we = 1'b0; d_addr = a;
         hi = 0; ackc = -1;
         for (int c = 0; c < T + 4; c++) begin
            @(negedge clk);
            if (mem_req_o === 1'b1) hi++;
            if (d_ack_o === 1'b1 && ackc < 0) begin
               ackc = c;
               checks++;
               if (bus_err_o !== exp_err) begin
                  errors++;
                  $display("FAIL to_bus_err r=%0d: got %b expected %b", r, bus_err_o, exp_err);
               end
               checks++;
               if (d_rdata_o !== (exp_err ? 32'h0 : rd_fn(a))) begin
                  errors++;
                  $display("FAIL to_rdata r=%0d: got %h expected %h",
                           r, d_rdata_o, exp_err ? 32'h0 : rd_fn(a));
               end
            end else begin
               checks++;
               if (bus_err_o !== 1'b0) begin
                  errors++;
                  $display("FAIL to_stray_err r=%0d c=%0d: got %b expected 0", r, c, bus_err_o);
               end
            end
            if (c == T + 2) begin
               checks++;
               if (busy_o !== 1'b0) begin
                  errors++;
                  $display("FAIL to_idle r=%0d: busy got %b expected 0", r, busy_o);
               end
            end
            @(posedge clk); #1;
            if (c == ackc) d_req = 1'b0;
         end
         checks++;
         if (hi !== T || ackc !== T + 1) begin
            errors++;
            $display("FAIL to_len r=%0d: mem_req cycles %0d ack cycle %0d, expected %0d and %0d",
                     r, hi, ackc, T, T + 1);
         end
      end
   endtask

   task automatic test_reset_mid_busy();
      reset_dut();
      fix_lat = 1000;
      if_req = 1'b1; if_addr = $urandom;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c == 1) begin
            checks++;
            if (mem_req_o !== 1'b1 || busy_o !== 1'b1) begin
               errors++;
               $display("FAIL rb_busy: got req=%b busy=%b expected 1 1", mem_req_o, busy_o);
            end
         end
         if (c >= 3) begin
            checks++;
            if ({mem_req_o, mem_we_o, if_ack_o, d_ack_o, bus_err_o, busy_o} !== 6'b0 ||
                mem_addr_o !== 32'h0 || if_rdata_o !== 32'h0) begin
               errors++;
               $display("FAIL rb_after c=%0d: got req=%b we=%b ia=%b da=%b err=%b busy=%b addr=%h ird=%h expected all 0",
                        c, mem_req_o, mem_we_o, if_ack_o, d_ack_o, bus_err_o, busy_o,
                        mem_addr_o, if_rdata_o);
            end
         end
         @(posedge clk); #1;
         if (c == 1) begin rst = 1'b1; if_req = 1'b0; end
         if (c == 2) begin rst = 1'b0; force_ack = 1'b1; end
         if (c == 4) force_ack = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      int          nack;
      logic [31:0] a;
      reset_dut();
      fix_lat = 1; salt = $urandom;
      a = $urandom;
      if_addr = a; if_req = 1'b1; nack = 0;
      for (int c = 0; c < 33; c++) begin
         @(negedge clk);
         checks++;
         if (if_ack_o !== (c < 30 && c % 3 == 2) || mem_req_o !== (c < 30 && c % 3 == 1)) begin
            errors++;
            $display("FAIL bb_timing c=%0d: got if_ack=%b mem_req=%b expected %b %b",
                     c, if_ack_o, mem_req_o, (c < 30 && c % 3 == 2), (c < 30 && c % 3 == 1));
         end
         if (if_ack_o === 1'b1) begin
            nack++;
            checks++;
            if (if_rdata_o !== rd_fn(a)) begin
               errors++;
               $display("FAIL bb_rdata c=%0d: got %h expected %h", c, if_rdata_o, rd_fn(a));
            end
         end
         @(posedge clk); #1;
         if (c == 29) if_req = 1'b0;
      end
      checks++;
      if (nack !== 10) begin
         errors++;
         $display("FAIL bb_count: got %0d acks expected 10", nack);
      end
   endtask

   task automatic test_random();
      bit          if_p, d_p, dwe, act, idle, is_ack, last_d, g_d, g_we;
      logic [31:0] ia, da, dw, g_addr, g_wdata, exp_ird, exp_drd, v;
      int          g_cyc, ack_cyc, g_lat;
      bit          e_mreq, e_busy;
      reset_dut();
      salt = $urandom; lat_mode = 1; stray_en = 1'b1;
      if_p = 0; d_p = 0; dwe = 0; act = 0; last_d = 0; g_d = 0; g_we = 0;
      ia = 0; da = 0; dw = 0; g_addr = 0; g_wdata = 0;
      exp_ird = 0; exp_drd = 0; g_cyc = -10; ack_cyc = -10; g_lat = 1;
      for (int c = 0; c < 700; c++) begin
         @(negedge clk);
         idle = !act;
         if (act && c == g_cyc + 1) begin
            g_lat = cur_lat;
            ack_cyc = c + ((g_lat < T) ? g_lat : T);
            checks++;
            if (mem_addr_o !== g_addr || mem_we_o !== g_we ||
                (g_we && mem_wdata_o !== g_wdata)) begin
               errors++;
               $display("FAIL rnd_grant c=%0d: got addr=%h we=%b wd=%h expected addr=%h we=%b wd=%h (port %s)",
                        c, mem_addr_o, mem_we_o, mem_wdata_o, g_addr, g_we, g_wdata, g_d ? "d" : "if");
            end
         end
         is_ack = act && (c == ack_cyc);
         e_mreq = act && (c < ack_cyc);
         e_busy = act;
         if (is_ack) begin
            v = (g_lat > T || g_we) ? 32'h0 : rd_fn(g_addr);
            if (g_d) exp_drd = v; else exp_ird = v;
         end
         checks++;
         if (mem_req_o !== e_mreq || busy_o !== e_busy) begin
            errors++;
            $display("FAIL rnd_req_busy c=%0d: got req=%b busy=%b expected %b %b",
                     c, mem_req_o, busy_o, e_mreq, e_busy);
         end
         checks++;
         if (if_ack_o !== (is_ack && !g_d) || d_ack_o !== (is_ack && g_d) ||
             bus_err_o !== (is_ack && g_lat > T)) begin
            errors++;
            $display("FAIL rnd_ack c=%0d: got ia=%b da=%b err=%b expected %b %b %b",
                     c, if_ack_o, d_ack_o, bus_err_o, is_ack && !g_d, is_ack && g_d,
                     is_ack && g_lat > T);
         end
         checks++;
         if (if_rdata_o !== exp_ird || d_rdata_o !== exp_drd) begin
            errors++;
            $display("FAIL rnd_rdata c=%0d: got if=%h d=%h expected if=%h d=%h",
                     c, if_rdata_o, d_rdata_o, exp_ird, exp_drd);
         end
         if (is_ack) begin
            act = 0;
            if (g_d) d_p = 0; else if_p = 0;
         end
         if (idle && (if_p || d_p)) begin
            g_d = (if_p && d_p) ? (RR ? !last_d : 1'b1) : d_p;
            last_d  = g_d;
            act     = 1;
            g_cyc   = c;
            g_addr  = g_d ? da : ia;
            g_we    = g_d ? dwe : 1'b0;
            g_wdata = dw;
         end
         if (c < 650) begin
            if (!if_p && $urandom_range(0, 2) != 0) begin
               if_p = 1; ia = $urandom;
            end
            if (!d_p && $urandom_range(0, 2) != 0) begin
               d_p = 1; da = $urandom; dwe = $urandom_range(0, 1); dw = $urandom;
            end
         end
         @(posedge clk); #1;
         if_req = if_p; if_addr = ia;
         d_req = d_p; d_addr = da; d_we = dwe; d_wdata = dw;
      end
      stray_en = 1'b0; lat_mode = 0;
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
      test_reset();
      test_single_fetch();
      test_contention();
      test_store();
      test_timeout();
      test_reset_mid_busy();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
